reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_2r1w.sv | 87 ++++++++
 tb/tb_reg_file_2r1w.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// 16x16 register file: one synchronous write port, two combinational read ports.
// Optional same-cycle write-to-read bypass is compiled in with `define RF_BYPASS_EN.
module reg_file_2r1w #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [WIDTH-1:0]  DstData,
    output logic [WIDTH-1:0]  SrcData1,
    output logic [WIDTH-1:0]  SrcData2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] entry_we_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // WriteReg is tested first so an unknown DstReg cannot enable a write while idle.
            always_comb begin
                if (WriteReg) begin
                    entry_we_s[gi] = (DstReg == ADDR_W'(gi));
                end else begin
                    entry_we_s[gi] = 1'b0;
                end
            end

            // Per-entry storage with its own write enable; reset clears it asynchronously.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_r[gi] <= {WIDTH{1'b0}};
                end else if (entry_we_s[gi]) begin
                    mem_r[gi] <= DstData;
                end else begin
                    mem_r[gi] <= mem_r[gi];
                end
            end
        end
    endgenerate

    // Read port 1: storage lookup, optional bypass, forced to zero during reset.
    always_comb begin
        rd1_s = mem_r[SrcReg1];
`ifdef RF_BYPASS_EN
        if (WriteReg && (SrcReg1 == DstReg)) begin
            rd1_s = DstData;
        end else begin
            rd1_s = mem_r[SrcReg1];
        end
`endif
        if (rst) begin
            rd1_s = {WIDTH{1'b0}};
        end else begin
            rd1_s = rd1_s;
        end
    end

    // Read port 2: identical behaviour to port 1.
    always_comb begin
        rd2_s = mem_r[SrcReg2];
`ifdef RF_BYPASS_EN
        if (WriteReg && (SrcReg2 == DstReg)) begin
            rd2_s = DstData;
        end else begin
            rd2_s = mem_r[SrcReg2];
        end
`endif
        if (rst) begin
            rd2_s = {WIDTH{1'b0}};
        end else begin
            rd2_s = rd2_s;
        end
    end

    assign SrcData1 = rd1_s;
    assign SrcData2 = rd2_s;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w; hazard expectations follow RF_BYPASS_EN.
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] model [16];

    reg_file_2r1w dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        WriteReg = 1'b1;
        DstReg   = addr;
        DstData  = data;
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        model[addr] = data;
    endtask

    task automatic read_pair(input logic [3:0] a, input logic [3:0] b, input string tag);
        SrcReg1 = a;
        SrcReg2 = b;
        #1;
        check($sformatf("%s_p1_r%0d", tag, a), SrcData1, model[a]);
        check($sformatf("%s_p2_r%0d", tag, b), SrcData2, model[b]);
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; WriteReg = 1'b0; DstReg = 4'd0; DstData = 16'h0000;
        SrcReg1 = 4'd0; SrcReg2 = 4'd15;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        #2;
        check("rst_hold_p1", SrcData1, 16'h0000);
        check("rst_hold_p2", SrcData2, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        read_pair(4'd3, 4'd12, "post_rst");

        // Reset between edges, with a write attempted in the reset cycle.
        for (int i = 0; i < 16; i++) write_entry(4'(i), 16'hFFFF);
        read_pair(4'd2, 4'd9, "all_ones");
        @(negedge clk);
        #2;
        SrcReg1 = 4'd2; SrcReg2 = 4'd9;
        WriteReg = 1'b1; DstReg = 4'd2; DstData = 16'h1357;
        rst = 1'b1;
        #1;
        check("rst_async_p1", SrcData1, 16'h0000);
        check("rst_async_p2", SrcData2, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_wr_cycle_p1", SrcData1, 16'h0000);
        WriteReg = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        for (int i = 0; i < 16; i++) read_pair(4'(i), 4'(15 - i), "rst_clear");

        // Sweep: entry i <- 0x1111*i + i, read pairs (i, 15-i).
        for (int i = 0; i < 16; i++) begin
            v = 16'h1111 * 16'(i) + 16'(i);
            write_entry(4'(i), v);
        end
        check("sweep_r15_value", model[15], 16'h000E);
        for (int i = 0; i < 16; i++) read_pair(4'(i), 4'(15 - i), "sweep");
        write_entry(4'd0, 16'h0000);
        read_pair(4'd0, 4'd0, "r0_zero");
        write_entry(4'd0, 16'hBEEF);
        read_pair(4'd0, 4'd0, "r0_beef");

        // Write disable, including an unknown address while idle.
        write_entry(4'd5, 16'h1234);
        @(negedge clk);
        WriteReg = 1'b0; DstReg = 4'd5; DstData = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        read_pair(4'd5, 4'd5, "wr_dis");
        @(negedge clk);
        DstReg = 4'bxxxx;
        @(posedge clk);
        #1;
        DstReg = 4'd0;
        for (int i = 0; i < 16; i++) read_pair(4'(i), 4'(15 - i), "x_addr");

        // Same-cycle hazard on entry 7.
        write_entry(4'd7, 16'h00AA);
        @(negedge clk);
        WriteReg = 1'b1; DstReg = 4'd7; DstData = 16'h5555;
        SrcReg1 = 4'd7; SrcReg2 = 4'd7;
        #1;
`ifdef RF_BYPASS_EN
        check("hazard_pre_p1", SrcData1, 16'h5555);
        check("hazard_pre_p2", SrcData2, 16'h5555);
`else
        check("hazard_pre_p1", SrcData1, 16'h00AA);
        check("hazard_pre_p2", SrcData2, 16'h00AA);
`endif
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        model[7] = 16'h5555;
        read_pair(4'd7, 4'd7, "hazard_post");

        // Back-to-back writes to entry 3, observed after each edge.
        SrcReg1 = 4'd3;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'(k);
            @(posedge clk);
            #1;
            check($sformatf("b2b_%0d", k), SrcData1, 16'(k));
        end
        WriteReg = 1'b0;
        model[3] = 16'h0003;
        for (int i = 0; i < 16; i++) read_pair(4'(i), 4'(15 - i), "final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
